// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one skid FIFO per result producer (ALU, LSB),
// a round-robin pick of one result per cycle, and a registered broadcast
// toward the ROB, reservation stations and LSB operand snooping.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_POS_W  = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  input  logic [DATA_W-1:0]    alu_val,
  input  logic                 alu_jump,
  input  logic [ADDR_W-1:0]    alu_pc,
  input  logic                 lsb_valid,
  output logic                 lsb_ready,
  input  logic [ROB_POS_W-1:0] lsb_rob_pos,
  input  logic [DATA_W-1:0]    lsb_val,
  output logic                 cdb_valid,
  output logic                 cdb_src,
  output logic [ROB_POS_W-1:0] cdb_rob_pos,
  output logic [DATA_W-1:0]    cdb_val,
  output logic                 cdb_jump,
  output logic [ADDR_W-1:0]    cdb_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Requester index doubles as the cdb_src encoding.
  localparam int   REQ_ALU = 0;
  localparam int   REQ_LSB = 1;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_POS_W-1:0] rob_pos;
    logic [DATA_W-1:0]    val;
    logic                 jump;
    logic [ADDR_W-1:0]    pc;
  } result_t;

  // Skid FIFO storage and bookkeeping, indexed by requester.
  result_t          r_mem    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr [2];
  logic [PTR_W-1:0] r_wr_ptr [2];
  logic [CNT_W-1:0] r_count  [2];
  logic             r_last_grant;

  result_t    w_live [2];
  result_t    w_head [2];
  logic [1:0] w_offer;
  logic [1:0] w_ready;
  logic [1:0] w_xfer;
  logic [1:0] w_cand;
  logic [1:0] w_win;
  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic       w_any;
  logic       w_grant;
  result_t    w_sel;

  assign alu_ready = w_ready[REQ_ALU];
  assign lsb_ready = w_ready[REQ_LSB];

  // Candidate selection, round-robin grant and FIFO push/pop decisions.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    w_live[REQ_ALU].rob_pos = alu_rob_pos;
    w_live[REQ_ALU].val     = alu_val;
    w_live[REQ_ALU].jump    = alu_jump;
    w_live[REQ_ALU].pc      = alu_pc;
    w_live[REQ_LSB].rob_pos = lsb_rob_pos;
    w_live[REQ_LSB].val     = lsb_val;
    w_live[REQ_LSB].jump    = 1'b0;
    w_live[REQ_LSB].pc      = '0;
    w_offer                 = {lsb_valid, alu_valid};
    w_ready                 = '0;
    w_xfer                  = '0;
    w_cand                  = '0;
    w_push                  = '0;
    w_pop                   = '0;
    w_head[REQ_ALU]         = w_live[REQ_ALU];
    w_head[REQ_LSB]         = w_live[REQ_LSB];

    for (int i = 0; i < 2; i++) begin
      // Ready depends on occupancy only, never on this cycle's grant.
      w_ready[i] = (r_count[i] < DEPTH_C);
      w_xfer[i]  = w_offer[i] & w_ready[i] & rdy;
      // A buffered head always goes before the live input.
      if (r_count[i] != '0) begin
        w_head[i] = r_mem[i][r_rd_ptr[i]];
      end
      w_cand[i] = (r_count[i] != '0) | w_xfer[i];
    end

    w_any   = |w_cand;
    // With both competing, the one not granted last wins; otherwise the lone candidate.
    w_grant = (&w_cand) ? ~r_last_grant : w_cand[REQ_LSB];
    w_win   = w_any ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    for (int i = 0; i < 2; i++) begin
      w_pop[i]  = w_win[i] & (r_count[i] != '0);
      // A granted live input with an empty FIFO bypasses storage entirely.
      w_push[i] = w_xfer[i] & ~(w_win[i] & (r_count[i] == '0));
    end

    w_sel = w_head[w_grant];
  end

  // FIFO payload storage; only written on a push outside rollback.
  always_ff @(posedge clk) begin
    // NOTE: payload RAM is not reset; occupancy counters alone decide which entries are meaningful.
    if (rdy && !rollback) begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wr_ptr[i]] <= w_live[i];
        end
      end
    end
  end

  // FIFO pointers, round-robin history and the registered broadcast.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_last_grant <= SRC_LSB;
      cdb_valid    <= 1'b0;
      cdb_src      <= 1'b0;
      cdb_rob_pos  <= '0;
      cdb_val      <= '0;
      cdb_jump     <= 1'b0;
      cdb_pc       <= '0;
    end else if (rdy) begin
      if (rollback) begin
        // Flush wins over everything: buffered and offered results are discarded.
        for (int i = 0; i < 2; i++) begin
          r_rd_ptr[i] <= '0;
          r_wr_ptr[i] <= '0;
          r_count[i]  <= '0;
        end
        r_last_grant <= SRC_LSB;
        cdb_valid    <= 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (w_push[i]) begin
            r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
          end
          if (w_pop[i]) begin
            r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
          end
          r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
        end
        if (w_any) begin
          r_last_grant <= w_grant;
          cdb_valid    <= 1'b1;
          cdb_src      <= w_grant;
          cdb_rob_pos  <= w_sel.rob_pos;
          cdb_val      <= w_sel.val;
          cdb_jump     <= w_sel.jump;
          cdb_pc       <= w_sel.pc;
        end else begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a directed vector table, hand-built
// multi-cycle corner sequences and a randomized run, all compared against a
// queue-based model of the bus-sharing rules.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;
  localparam int RW    = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic          rollback = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [RW-1:0] alu_rob_pos = '0;
  logic [DW-1:0] alu_val = '0;
  logic          alu_jump = 1'b0;
  logic [AW-1:0] alu_pc = '0;
  logic          lsb_valid = 1'b0;
  logic          lsb_ready;
  logic [RW-1:0] lsb_rob_pos = '0;
  logic [DW-1:0] lsb_val = '0;
  logic          cdb_valid;
  logic          cdb_src;
  logic [RW-1:0] cdb_rob_pos;
  logic [DW-1:0] cdb_val;
  logic          cdb_jump;
  logic [AW-1:0] cdb_pc;

  cdb_arbiter #(
    .FIFO_DEPTH(DEPTH), .ROB_POS_W(RW), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_pos(alu_rob_pos),
    .alu_val(alu_val), .alu_jump(alu_jump), .alu_pc(alu_pc),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_rob_pos(lsb_rob_pos),
    .lsb_val(lsb_val),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_pos(cdb_rob_pos),
    .cdb_val(cdb_val), .cdb_jump(cdb_jump), .cdb_pc(cdb_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          src;
    logic [RW-1:0] tag;
    logic [DW-1:0] val;
    logic          jump;
    logic [AW-1:0] pc;
  } res_t;

  // Producer backlogs (what each producer still has to hand over).
  res_t pend_a[$];
  res_t pend_l[$];
  // Reference model: one queue per producer, last winner, expected bus.
  res_t mq_a[$];
  res_t mq_l[$];
  logic m_last;
  logic m_valid;
  res_t m_out;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq_a.delete();
    mq_l.delete();
    pend_a.delete();
    pend_l.delete();
    m_last  = 1'b1;
    m_valid = 1'b0;
    m_out   = '{src: 1'b0, tag: '0, val: '0, jump: 1'b0, pc: '0};
  endtask

  task automatic idle();
    rdy       = 1'b1;
    rollback  = 1'b0;
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    idle();
  endtask

  // Drive each producer's oldest pending result, holding it until taken.
  task automatic offer();
    alu_valid = (pend_a.size() != 0);
    if (alu_valid) begin
      alu_rob_pos = pend_a[0].tag;
      alu_val     = pend_a[0].val;
      alu_jump    = pend_a[0].jump;
      alu_pc      = pend_a[0].pc;
    end
    lsb_valid = (pend_l.size() != 0);
    if (lsb_valid) begin
      lsb_rob_pos = pend_l[0].tag;
      lsb_val     = pend_l[0].val;
    end
  endtask

  task automatic add_alu(input logic [RW-1:0] tag);
    pend_a.push_back('{src: 1'b0, tag: tag, val: $urandom, jump: 1'($urandom), pc: $urandom});
  endtask

  task automatic add_lsb(input logic [RW-1:0] tag);
    pend_l.push_back('{src: 1'b1, tag: tag, val: $urandom, jump: 1'b0, pc: '0});
  endtask

  task automatic compare(input string tag);
    check({tag, " valid"}, 64'(cdb_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, " src"},  64'(cdb_src),     64'(m_out.src));
      check({tag, " tag"},  64'(cdb_rob_pos), 64'(m_out.tag));
      check({tag, " val"},  64'(cdb_val),     64'(m_out.val));
      check({tag, " jump"}, 64'(cdb_jump),    64'(m_out.jump));
      check({tag, " pc"},   64'(cdb_pc),      64'(m_out.pc));
    end
    check({tag, " alu_ready"}, 64'(alu_ready), 64'(mq_a.size() < DEPTH));
    check({tag, " lsb_ready"}, 64'(lsb_ready), 64'(mq_l.size() < DEPTH));
  endtask

  // One clock: apply the bus-sharing rules to the model, clock the DUT, compare.
  task automatic tick(input string tag);
    bit   xa;
    bit   xl;
    res_t ea;
    res_t el;
    xa = alu_valid && (mq_a.size() < DEPTH) && rdy;
    xl = lsb_valid && (mq_l.size() < DEPTH) && rdy;
    ea = '{src: 1'b0, tag: alu_rob_pos, val: alu_val, jump: alu_jump, pc: alu_pc};
    el = '{src: 1'b1, tag: lsb_rob_pos, val: lsb_val, jump: 1'b0, pc: '0};
    if (rdy) begin
      if (rollback) begin
        mq_a.delete();
        mq_l.delete();
        m_last  = 1'b1;
        m_valid = 1'b0;
      end else begin
        // Arrival order then oldest-first service is exactly FIFO-with-bypass.
        if (xa) mq_a.push_back(ea);
        if (xl) mq_l.push_back(el);
        if (mq_a.size() > 0 && (mq_l.size() == 0 || m_last == 1'b1)) begin
          m_out   = mq_a.pop_front();
          m_valid = 1'b1;
          m_last  = 1'b0;
        end else if (mq_l.size() > 0) begin
          m_out   = mq_l.pop_front();
          m_valid = 1'b1;
          m_last  = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    if (xa && pend_a.size() > 0) void'(pend_a.pop_front());
    if (xl && pend_l.size() > 0) void'(pend_l.pop_front());
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      offer();
      tick(tag);
    end
  endtask

  typedef struct {
    bit            do_rst;
    bit            av;
    logic [RW-1:0] atag;
    logic [DW-1:0] aval;
    bit            lv;
    logic [RW-1:0] ltag;
    bit            ev;
    bit            es;
    logic [RW-1:0] et;
    bit            ear;
    bit            elr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Single ALU result, then idle.
    tbl[0] = '{1, 1, 4'd3, 32'h11,  0, 4'd0,  1, 0, 4'd3,  1, 1};
    tbl[1] = '{0, 0, 4'd0, 32'h0,   0, 4'd0,  0, 0, 4'd0,  1, 1};
    // Both producers valid each cycle, holding until accepted.
    tbl[2] = '{1, 1, 4'd1, 32'h101, 1, 4'd8,  1, 0, 4'd1,  1, 1};
    tbl[3] = '{0, 1, 4'd2, 32'h102, 1, 4'd9,  1, 1, 4'd8,  1, 1};
    tbl[4] = '{0, 1, 4'd3, 32'h103, 1, 4'd10, 1, 0, 4'd2,  1, 0};
    tbl[5] = '{0, 0, 4'd0, 32'h0,   0, 4'd0,  1, 1, 4'd9,  1, 1};
    tbl[6] = '{0, 0, 4'd0, 32'h0,   0, 4'd0,  1, 0, 4'd3,  1, 1};
    tbl[7] = '{0, 0, 4'd0, 32'h0,   0, 4'd0,  1, 1, 4'd10, 1, 1};
    tbl[8] = '{0, 0, 4'd0, 32'h0,   0, 4'd0,  0, 0, 4'd0,  1, 1};

    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    model_reset();
    check("reset cdb_valid", 64'(cdb_valid), 64'd0);
    check("reset cdb_src", 64'(cdb_src), 64'd0);
    check("reset cdb_rob_pos", 64'(cdb_rob_pos), 64'd0);
    check("reset cdb_val", 64'(cdb_val), 64'd0);
    check("reset cdb_jump", 64'(cdb_jump), 64'd0);
    check("reset cdb_pc", 64'(cdb_pc), 64'd0);
    check("reset alu_ready", 64'(alu_ready), 64'd1);
    check("reset lsb_ready", 64'(lsb_ready), 64'd1);

    // Directed vector table.
    for (int k = 0; k < 9; k++) begin
      if (tbl[k].do_rst) do_reset();
      alu_valid   = tbl[k].av;
      alu_rob_pos = tbl[k].atag;
      alu_val     = tbl[k].aval;
      alu_jump    = tbl[k].atag[0];
      alu_pc      = AW'(tbl[k].atag) << 2;
      lsb_valid   = tbl[k].lv;
      lsb_rob_pos = tbl[k].ltag;
      lsb_val     = DW'(tbl[k].ltag) << 8;
      tick($sformatf("tbl%0d model", k));
      check($sformatf("tbl%0d valid", k), 64'(cdb_valid), 64'(tbl[k].ev));
      if (tbl[k].ev) begin
        check($sformatf("tbl%0d src", k), 64'(cdb_src), 64'(tbl[k].es));
        check($sformatf("tbl%0d tag", k), 64'(cdb_rob_pos), 64'(tbl[k].et));
      end
      check($sformatf("tbl%0d alu_ready", k), 64'(alu_ready), 64'(tbl[k].ear));
      check($sformatf("tbl%0d lsb_ready", k), 64'(lsb_ready), 64'(tbl[k].elr));
    end
    idle();

    // Backlog on both sides: occupancy limits and in-order drain.
    do_reset();
    for (int t = 1; t <= 5; t++) add_alu(RW'(t));
    for (int t = 8; t <= 12; t++) add_lsb(RW'(t));
    run(14, "drain");

    // Rollback with both FIFOs occupied.
    do_reset();
    for (int t = 1; t <= 4; t++) add_alu(RW'(t));
    for (int t = 8; t <= 11; t++) add_lsb(RW'(t));
    run(3, "prefill");
    rollback = 1'b1;
    offer();
    tick("rollback");
    rollback = 1'b0;
    check("rollback cdb_valid", 64'(cdb_valid), 64'd0);
    check("rollback alu_ready", 64'(alu_ready), 64'd1);
    check("rollback lsb_ready", 64'(lsb_ready), 64'd1);
    pend_a.delete();
    pend_l.delete();
    add_alu(RW'(5));
    add_lsb(RW'(6));
    run(1, "post rollback");
    check("post rollback src", 64'(cdb_src), 64'd0);
    check("post rollback tag", 64'(cdb_rob_pos), 64'd5);
    run(2, "post rollback drain");

    // rdy low while tag 7 is on the bus.
    do_reset();
    add_alu(RW'(7));
    run(1, "tag7");
    add_alu(RW'(8));
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer();
      tick("stall");
      check("stall valid", 64'(cdb_valid), 64'd1);
      check("stall tag", 64'(cdb_rob_pos), 64'd7);
    end
    rdy = 1'b1;
    run(1, "resume");
    check("resume tag", 64'(cdb_rob_pos), 64'd8);
    run(2, "resume drain");

    // Asynchronous reset between edges with a full FIFO.
    do_reset();
    for (int t = 1; t <= 3; t++) add_alu(RW'(t));
    for (int t = 8; t <= 10; t++) add_lsb(RW'(t));
    run(3, "fill");
    check("fill lsb_ready", 64'(lsb_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async cdb_valid", 64'(cdb_valid), 64'd0);
    check("async cdb_rob_pos", 64'(cdb_rob_pos), 64'd0);
    check("async cdb_val", 64'(cdb_val), 64'd0);
    check("async cdb_src", 64'(cdb_src), 64'd0);
    check("async cdb_jump", 64'(cdb_jump), 64'd0);
    check("async cdb_pc", 64'(cdb_pc), 64'd0);
    #1;
    rst = 1'b0;
    model_reset();
    idle();
    check("async alu_ready", 64'(alu_ready), 64'd1);
    check("async lsb_ready", 64'(lsb_ready), 64'd1);
    tick("after async");

    // Randomized traffic with stalls and rollbacks.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (pend_a.size() < 3 && $urandom_range(0, 1) == 1) add_alu(RW'($urandom));
      if (pend_l.size() < 3 && $urandom_range(0, 1) == 1) add_lsb(RW'($urandom));
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 39) == 0);
      offer();
      tick("random");
    end
    idle();
    run(8, "final drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
